// File: rtl/recovery_sequencer.sv
// Recovery sequencer: picks the oldest refetch request, then drives the
// flush / redirect / stall sequence COMMIT -> RECOVER_0 -> RECOVER_1.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   reqValid/Type/Ptr/PC     per-source refetch requests (flattened)
//   csrTarget                trap vector used by the *_TO_CSR types
//   alHeadPtr, alTailPtr     active-list head/tail
//   recoveryDone             back-end walk complete (read in RECOVER_1)
//   phase                    0 COMMIT, 1 RECOVER_0, 2 RECOVER_1
//   flushValid/HeadPtr/TailPtr  selective-flush range
//   refetchValid/Type/PC     fetch redirect
//   stageClear, frontStall   pipeline clear pulse, front-end stall
//   timeoutErr               sticky watchdog flag
module recovery_sequencer #(
   parameter int NUM_SRC = 3,
   parameter int AL_W    = 6,
   parameter int PC_W    = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_SRC-1:0]      reqValid,
   input  logic [3*NUM_SRC-1:0]    reqType,
   input  logic [AL_W*NUM_SRC-1:0] reqPtr,
   input  logic [PC_W*NUM_SRC-1:0] reqPC,
   input  logic [PC_W-1:0]         csrTarget,
   input  logic [AL_W-1:0]         alHeadPtr,
   input  logic [AL_W-1:0]         alTailPtr,
   input  logic                    recoveryDone,
   output logic [1:0]              phase,
   output logic                    flushValid,
   output logic [AL_W-1:0]         flushHeadPtr,
   output logic [AL_W-1:0]         flushTailPtr,
   output logic                    refetchValid,
   output logic [2:0]              refetchType,
   output logic [PC_W-1:0]         refetchPC,
   output logic                    stageClear,
   output logic                    frontStall,
   output logic                    timeoutErr
);

   typedef enum logic [1:0] {
      COMMIT    = 2'd0,
      RECOVER_0 = 2'd1,
      RECOVER_1 = 2'd2
   } state_t;

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic            r_flush;
   logic [AL_W-1:0] r_head;
   logic [AL_W-1:0] r_tail;
   logic            r_refetch;
   logic [2:0]      r_type;
   logic [PC_W-1:0] r_pc;
   logic            r_clear;
   logic            r_stall;
   logic            r_err;

   logic            w_any;
   logic [AL_W-1:0] w_age;
   logic [2:0]      w_type;
   logic [AL_W-1:0] w_ptr;
   logic [PC_W-1:0] w_pc;
   logic [AL_W-1:0] w_head;
   logic [PC_W-1:0] w_tgt;
   logic            w_this;
   logic            w_csr;

   // Oldest request wins; strict '<' keeps the lowest index on a tie.
   always_comb begin
      logic [AL_W-1:0] v_age;
      v_age  = '0;
      w_any  = 1'b0;
      w_age  = '1;
      w_type = '0;
      w_ptr  = '0;
      w_pc   = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (reqValid[i]) begin
            v_age = reqPtr[i*AL_W +: AL_W] - alHeadPtr;
            if (!w_any || v_age < w_age) begin
               w_any  = 1'b1;
               w_age  = v_age;
               w_type = reqType[i*3 +: 3];
               w_ptr  = reqPtr[i*AL_W +: AL_W];
               w_pc   = reqPC[i*PC_W +: PC_W];
            end
         end
      end
   end

   // THIS_PC and THIS_PC_TO_CSR re-execute the faulting op itself.
   assign w_this = (w_type == 3'b000) || (w_type == 3'b101);
   assign w_csr  = (w_type == 3'b100) || (w_type == 3'b101);
   assign w_head = w_this ? w_ptr : w_ptr + AL_W'(1);
   assign w_tgt  = w_csr ? csrTarget : w_pc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= COMMIT;
         r_cnt     <= '0;
         r_flush   <= 1'b0;
         r_head    <= '0;
         r_tail    <= '0;
         r_refetch <= 1'b0;
         r_type    <= '0;
         r_pc      <= '0;
         r_clear   <= 1'b0;
         r_stall   <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         unique case (r_state)
            COMMIT: begin
               if (w_any) begin
                  r_state   <= RECOVER_0;
                  r_head    <= w_head;
                  r_tail    <= alTailPtr;
                  r_type    <= w_type;
                  r_pc      <= w_tgt;
                  r_flush   <= 1'b1;
                  r_refetch <= 1'b1;
                  r_clear   <= 1'b1;
                  r_stall   <= 1'b1;
               end
            end
            RECOVER_0: begin
               r_state   <= RECOVER_1;
               r_cnt     <= '0;
               r_refetch <= 1'b0;
               r_clear   <= 1'b0;
            end
            RECOVER_1: begin
               r_cnt <= r_cnt + CW'(1);
               if (recoveryDone || r_cnt == LAST) begin
                  r_state <= COMMIT;
                  r_flush <= 1'b0;
                  r_stall <= 1'b0;
                  if (!recoveryDone) r_err <= 1'b1;
               end
            end
            default: begin
               r_state <= COMMIT;
               r_flush <= 1'b0;
               r_stall <= 1'b0;
            end
         endcase
      end
   end

   assign phase        = r_state;
   assign flushValid   = r_flush;
   assign flushHeadPtr = r_head;
   assign flushTailPtr = r_tail;
   assign refetchValid = r_refetch;
   assign refetchType  = r_type;
   assign refetchPC    = r_pc;
   assign stageClear   = r_clear;
   assign frontStall   = r_stall;
   assign timeoutErr   = r_err;

endmodule
